// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Responder side of the core's data-memory interface. Loads are served from
//   a single-port synchronous BRAM with one stall cycle covering the read
//   latency. Stores are posted into a one-entry write buffer that drains
//   whenever the port is free. Loads see buffered bytes through forwarding.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   ram_load_en/addr    load request (held by the core while ram_stall=1)
//   ram_load_data       right-aligned load word, valid in the response cycle
//   ram_store_en/addr/data/width  store request (width 00 byte, 01 half, 10 word)
//   ram_stall           core must hold its request inputs this cycle
//   misaligned_fault    registered one-cycle pulse for an illegal store alignment/width
//   access_fault        registered one-cycle pulse for an access outside the window
//   mem_en/we/addr/wdata  BRAM port drive
//   mem_rdata           BRAM read data, valid the cycle after a read
module data_ram_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_load_en,
    input  logic [31:0]           ram_load_addr,
    output logic [31:0]           ram_load_data,
    input  logic                  ram_store_en,
    input  logic [31:0]           ram_store_addr,
    input  logic [31:0]           ram_store_data,
    input  logic [1:0]            ram_store_width,
    output logic                  ram_stall,
    output logic                  misaligned_fault,
    output logic                  access_fault,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int HI = ADDR_WIDTH + 2;

    typedef enum logic {IDLE = 1'b0, LOAD_RESP = 1'b1} state_t;

    function automatic logic in_window(input logic [31:0] a);
        return a[31:HI] == BASE_ADDR[31:HI];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [31:0] a);
        return a[HI-1:2];
    endfunction

    function automatic logic store_misaligned(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] width, input logic [31:0] d);
        case (width)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] r, input logic [31:0] w,
                                                input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = be[b] ? w[8*b +: 8] : r[8*b +: 8];
        end
        return m;
    endfunction

    state_t                state;
    logic                  buf_valid;
    logic [ADDR_WIDTH-1:0] buf_idx;
    logic [3:0]            buf_be;
    logic [31:0]           buf_wdata;
    logic [ADDR_WIDTH-1:0] load_idx_p1;
    logic [1:0]            load_off_p1;

    logic load_issue, load_miss, drain;
    logic store_take, store_mis, store_miss, store_ok;
    logic [31:0] merged;

    // Request decode. Everything is gated by rst so nothing reaches the BRAM
    // while reset is held (a buffered store must be discarded, not drained).
    always_comb begin
        load_issue = !rst && (state == IDLE) && ram_load_en && in_window(ram_load_addr);
        load_miss  = !rst && (state == IDLE) && ram_load_en && !in_window(ram_load_addr);
        // A store colliding with a load issue while the buffer is full would also
        // stall, but that case is already covered since a load issue always stalls.
        ram_stall  = load_issue;
        store_take = !rst && ram_store_en && !ram_stall;
        store_mis  = store_take && store_misaligned(ram_store_width, ram_store_addr[1:0]);
        store_miss = store_take && !store_mis && !in_window(ram_store_addr);
        store_ok   = store_take && !store_mis && in_window(ram_store_addr);
        drain      = !rst && buf_valid && !load_issue;
    end

    // BRAM port: load issue has priority over draining the write buffer.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (load_issue) begin
            mem_en   = 1'b1;
            mem_addr = word_idx(ram_load_addr);
        end else if (drain) begin
            mem_en    = 1'b1;
            mem_we    = buf_be;
            mem_addr  = buf_idx;
            mem_wdata = buf_wdata;
        end
    end

    // Response stage: the buffer has not reached the BRAM yet if it is still
    // valid here, so its bytes override the read data for the same word.
    always_comb begin
        merged = mem_rdata;
        if (buf_valid && (buf_idx == load_idx_p1)) begin
            merged = merge_lanes(mem_rdata, buf_wdata, buf_be);
        end
        ram_load_data = 32'h0;
        if (!rst && (state == LOAD_RESP)) begin
            ram_load_data = merged >> {load_off_p1, 3'b000};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            buf_valid        <= 1'b0;
            misaligned_fault <= 1'b0;
            access_fault     <= 1'b0;
        end else begin
            case (state)
                IDLE:      if (load_issue) state <= LOAD_RESP;
                LOAD_RESP: state <= IDLE;
            endcase
            // A capture in the same cycle as a drain wins: the old entry is
            // being written this edge and the new store takes its place.
            if (store_ok) begin
                buf_valid <= 1'b1;
            end else if (drain) begin
                buf_valid <= 1'b0;
            end
            misaligned_fault <= store_mis;
            access_fault     <= load_miss | store_miss;
        end
    end

    // Issue -> response stage boundary, plus write-buffer payload.
    always_ff @(posedge clk) begin
        if (load_issue) begin
            load_idx_p1 <= word_idx(ram_load_addr);
            load_off_p1 <= ram_load_addr[1:0];
        end
        if (store_ok) begin
            buf_idx   <= word_idx(ram_store_addr);
            buf_be    <= store_be(ram_store_width, ram_store_addr[1:0]);
            buf_wdata <= store_wdata(ram_store_width, ram_store_data);
        end
    end

endmodule
